// File: rtl/agc_monitor_sequencer.sv
// Purpose: sequences AGC monitor START/STOP/LOAD commands onto MSTRT/MSTP/MLOAD/MDT.
// Latency: STOP/reserved finish one cycle after acceptance; START after PULSE_CYC; LOAD tracks MT12 edges.
// Backpressure: cmd_ready is high only in IDLE; one command is in flight at a time.
//
// Ports:
//   SIM_CLK, SIM_RST_n             clock, async active-low reset
//   cmd_valid/cmd_op/cmd_data      host command (op 0 START, 1 STOP, 2 LOAD, 3 reserved)
//   cmd_ready, done, err           handshake ready, completion pulse, error pulse with done
//   MT[11:0], MGOJAM               AGC timepulses and GOJAM monitor (asynchronous)
//   MSTRT, MSTP, MLOAD, MDT[15:0]  monitor controls and data bus toward the AGC
module agc_monitor_sequencer #(
  parameter int PULSE_CYC = 250,
  parameter int TMO_CYC   = 4095
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  output logic        done,
  output logic        err,
  input  logic [11:0] MT,
  input  logic        MGOJAM,
  output logic        MSTRT,
  output logic        MSTP,
  output logic        MLOAD,
  output logic [15:0] MDT
);

  // One counter serves both the START pulse width and the LOAD edge timeout.
  localparam int MAX_CYC = (PULSE_CYC > TMO_CYC) ? PULSE_CYC : TMO_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TMO_CYC - 1);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_LWAIT,
    ST_LDRIVE,
    ST_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mstrt_q, mstrt_d;
  logic          mstp_q, mstp_d;
  logic          mload_q, mload_d;
  logic [15:0]   mdt_q, mdt_d;
  logic [15:0]   data_q, data_d;
  logic          err_q, err_d;
  logic          alive_q;

  // Synchronizers for the two asynchronous AGC signals that matter here.
  logic mt12_s1_q, mt12_s2_q, mt12_prev_q;
  logic gj_s1_q, gj_s2_q;
  logic mt12_rise;

  // Only MT12 marks the memory cycle boundary; the other timepulses are ignored.
  logic unused_mt_bits;
  assign unused_mt_bits = ^MT[10:0];

  assign mt12_rise = mt12_s2_q & ~mt12_prev_q;

  // alive_q keeps cmd_ready low while reset is held and until the first edge after release.
  assign cmd_ready = (state_q == ST_IDLE) && alive_q;
  assign done      = (state_q == ST_FIN);
  assign err       = (state_q == ST_FIN) && err_q;
  assign MSTRT     = mstrt_q;
  assign MSTP      = mstp_q;
  assign MLOAD     = mload_q;
  assign MDT       = mdt_q;

  always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mstrt_q     <= 1'b0;
      mstp_q      <= 1'b0;
      mload_q     <= 1'b0;
      mdt_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      alive_q     <= 1'b0;
      mt12_s1_q   <= 1'b0;
      mt12_s2_q   <= 1'b0;
      mt12_prev_q <= 1'b0;
      gj_s1_q     <= 1'b0;
      gj_s2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mstrt_q     <= mstrt_d;
      mstp_q      <= mstp_d;
      mload_q     <= mload_d;
      mdt_q       <= mdt_d;
      data_q      <= data_d;
      err_q       <= err_d;
      alive_q     <= 1'b1;
      mt12_s1_q   <= MT[11];
      mt12_s2_q   <= mt12_s1_q;
      mt12_prev_q <= mt12_s2_q;
      gj_s1_q     <= MGOJAM;
      gj_s2_q     <= gj_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mstrt_d = mstrt_q;
    mstp_d  = mstp_q;
    mload_d = mload_q;
    mdt_d   = mdt_q;
    data_d  = data_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          data_d = cmd_data;
          cnt_d  = '0;
          err_d  = 1'b0;
          case (cmd_op)
            OP_START: begin
              mstp_d  = 1'b0;
              mstrt_d = 1'b1;
              state_d = ST_PULSE;
            end
            OP_STOP: begin
              mstp_d  = 1'b1;
              state_d = ST_FIN;
            end
            OP_LOAD: begin
              state_d = ST_LWAIT;
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_FIN;
            end
          endcase
        end
      end

      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          mstrt_d = 1'b0;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // An edge arriving on the very cycle the timeout expires still wins.
      ST_LWAIT: begin
        if (mt12_rise) begin
          mload_d = 1'b1;
          mdt_d   = data_q;
          cnt_d   = '0;
          state_d = ST_LDRIVE;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // GOJAM abort outranks the closing MT12 edge, which outranks the timeout.
      ST_LDRIVE: begin
        if (gj_s2_q) begin
          mload_d = 1'b0;
          mdt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (mt12_rise) begin
          mload_d = 1'b0;
          mdt_d   = '0;
          state_d = ST_FIN;
        end else if (cnt_q == TMO_LAST) begin
          mload_d = 1'b0;
          mdt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_agc_monitor_sequencer.sv
// Purpose: self-checking bench for agc_monitor_sequencer against a timestamp-based behavioural model.
// Latency: model predicts every output per cycle from accept/edge cycle numbers.
// Backpressure: commands are held until cmd_ready is observed, with bounded waits.
module tb_agc_monitor_sequencer;

  localparam int PULSE   = 250;
  localparam int TMO     = 4095;
  localparam int MT_HALF = 292;     // 584-cycle MT12 period, about 11.7 us at 50 MHz
  localparam int HN      = 32768;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cmd_ready, done, err;
  logic [11:0] MT;
  logic        MGOJAM;
  logic        MSTRT, MSTP, MLOAD;
  logic [15:0] MDT;

  agc_monitor_sequencer #(.PULSE_CYC(PULSE), .TMO_CYC(TMO)) dut (
    .SIM_CLK   (SIM_CLK),
    .SIM_RST_n (SIM_RST_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .done      (done),
    .err       (err),
    .MT        (MT),
    .MGOJAM    (MGOJAM),
    .MSTRT     (MSTRT),
    .MSTP      (MSTP),
    .MLOAD     (MLOAD),
    .MDT       (MDT)
  );

  always #10 SIM_CLK = ~SIM_CLK;

  // ---------------- behavioural model ----------------
  // Input history per rising edge; the synchronizer is "value seen two edges ago".
  bit          h_mt [HN];
  bit          h_gj [HN];
  int          n, base;
  bit          m_busy, m_alive, m_err, m_mstp;
  logic [1:0]  m_op;
  logic [15:0] m_data;
  int          m_a, m_e1, m_end;
  bit          exp_ready, exp_done, exp_err, exp_mstrt, exp_mstp, exp_mload;
  logic [15:0] exp_mdt;

  function automatic bit smp_mt(input int i);
    return (i >= base && i >= 0 && i < HN) ? h_mt[i] : 1'b0;
  endfunction

  function automatic bit smp_gj(input int i);
    return (i >= base && i >= 0 && i < HN) ? h_gj[i] : 1'b0;
  endfunction

  // Edge n acts on an MT12 rise when sample n-2 is high and sample n-3 low.
  function automatic bit mt_rise_at(input int e);
    return smp_mt(e - 2) && !smp_mt(e - 3);
  endfunction

  initial begin
    n = 0; base = 0; m_end = -1; m_e1 = -1; m_a = 0;
    forever begin
      @(posedge SIM_CLK or negedge SIM_RST_n);
      if (!SIM_RST_n) begin
        base = n + 1;
        m_busy = 0; m_alive = 0; m_err = 0; m_mstp = 0; m_end = -1; m_e1 = -1;
        exp_ready = 0; exp_done = 0; exp_err = 0; exp_mstrt = 0; exp_mstp = 0;
        exp_mload = 0; exp_mdt = '0;
      end else begin
        n++;
        if (n < HN) begin
          h_mt[n] = MT[11];
          h_gj[n] = MGOJAM;
        end
        if (m_busy) begin
          if (m_end >= 0) begin
            if (n == m_end + 1) m_busy = 0;
          end else if (m_op == 2'd2) begin
            if (m_e1 < 0) begin
              if (mt_rise_at(n)) m_e1 = n;
              else if (n == m_a + TMO) begin m_end = n; m_err = 1; end
            end else begin
              if (smp_gj(n - 2)) begin m_end = n; m_err = 1; end
              else if (mt_rise_at(n)) m_end = n;
              else if (n == m_e1 + TMO) begin m_end = n; m_err = 1; end
            end
          end
        end else if (m_alive && cmd_valid) begin
          m_busy = 1; m_a = n; m_op = cmd_op; m_data = cmd_data;
          m_e1 = -1; m_end = -1; m_err = 0;
          case (cmd_op)
            2'd0: begin m_mstp = 0; m_end = n + PULSE; end
            2'd1: begin m_mstp = 1; m_end = n; end
            2'd2: ;
            default: begin m_end = n; m_err = 1; end
          endcase
        end
        m_alive = 1;
        exp_ready = m_alive && !m_busy;
        exp_mstp  = m_mstp;
        exp_mstrt = m_busy && (m_op == 2'd0) && (n < m_a + PULSE);
        exp_mload = m_busy && (m_op == 2'd2) && (m_e1 >= 0) && (m_end < 0 || n < m_end);
        exp_mdt   = exp_mload ? m_data : 16'h0000;
        exp_done  = m_busy && (n == m_end);
        exp_err   = exp_done && m_err;
      end
    end
  end

  // ---------------- compare process ----------------
  int   n_chk, n_fail;
  bit   chk_en;
  int   nc, hs_cyc, gj_cyc, mstrt_run, mload_run, busy_run;
  bit   hs_pend, mload_seen;
  logic [1:0] hs_op;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; nc = 0; hs_pend = 0; gj_cyc = -1;
    mstrt_run = 0; mload_run = 0; busy_run = 0; mload_seen = 0; hs_cyc = 0; hs_op = 2'd0;
    forever begin
      @(negedge SIM_CLK or negedge SIM_RST_n);
      if (chk_en) begin
        if (!SIM_RST_n) #1;
        nc++;
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        chk("done",      32'(done),      32'(exp_done));
        chk("err",       32'(err),       32'(exp_err));
        chk("MSTRT",     32'(MSTRT),     32'(exp_mstrt));
        chk("MSTP",      32'(MSTP),      32'(exp_mstp));
        chk("MLOAD",     32'(MLOAD),     32'(exp_mload));
        chk("MDT",       32'(MDT),       32'(exp_mdt));
        if (!SIM_RST_n) begin
          hs_pend = 0; gj_cyc = -1; mstrt_run = 0; mload_run = 0; busy_run = 0; mload_seen = 0;
        end else begin
          // Literal pins on pulse widths and completion latencies.
          if (MSTRT) mstrt_run++;
          else if (mstrt_run > 0) begin
            chk("mstrt_width", 32'(mstrt_run), 32'd250);
            mstrt_run = 0;
          end
          if (MLOAD) begin mload_run++; mload_seen = 1; end
          if (hs_pend && MGOJAM && gj_cyc < 0) gj_cyc = nc;
          if (done && hs_pend) begin
            case (hs_op)
              2'd0: chk("start_latency", 32'(nc - hs_cyc), 32'd251);
              2'd1: chk("stop_latency", 32'(nc - hs_cyc), 32'd1);
              2'd3: begin
                chk("rsv_latency", 32'(nc - hs_cyc), 32'd1);
                chk("rsv_err", 32'(err), 32'd1);
              end
              default: begin
                if (!mload_seen) begin
                  chk("load_tmo_latency", 32'(nc - hs_cyc), 32'd4096);
                  chk("load_tmo_err", 32'(err), 32'd1);
                end else if (!err) begin
                  chk("mload_width", 32'(mload_run), 32'd584);
                end else if (gj_cyc >= 0) begin
                  chk("gojam_abort_within_3", 32'((nc - gj_cyc) <= 3), 32'd1);
                end
              end
            endcase
            hs_pend = 0;
          end
          if (cmd_valid && cmd_ready) begin
            hs_pend = 1; hs_cyc = nc; hs_op = cmd_op;
            mload_run = 0; mload_seen = 0; gj_cyc = -1;
          end
          if (!cmd_ready) busy_run++;
          else busy_run = 0;
          if (busy_run == 6000) chk("ready_returns_within_budget", 32'(cmd_ready), 32'd1);
        end
      end
    end
  end

  // ---------------- MT12 generator ----------------
  bit mt_run;
  logic mt12;

  initial begin
    int mtc;
    mtc = 0; mt12 = 1'b0;
    MT = {1'b0, 11'h2A5};
    forever begin
      @(posedge SIM_CLK); #2;
      if (mt_run) begin
        mtc++;
        if (mtc == MT_HALF) begin mt12 = ~mt12; mtc = 0; end
      end else begin
        mt12 = 1'b0; mtc = 0;
      end
      MT = {mt12, 11'h2A5};
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int k);
    repeat (k) @(posedge SIM_CLK);
    #2;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] d);
    @(posedge SIM_CLK); #2;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge SIM_CLK);
      if (cmd_ready) break;
    end
    @(posedge SIM_CLK); #2;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 16'h0000;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge SIM_CLK);
      if (done) break;
    end
  endtask

  task automatic wait_mload(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge SIM_CLK);
      if (MLOAD) break;
    end
  endtask

  initial begin
    chk_en = 1'b1;
    SIM_RST_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 16'h0000; MGOJAM = 1'b0;
    #1 SIM_RST_n = 1'b0;
    repeat (3) @(posedge SIM_CLK);
    #2 SIM_RST_n = 1'b1;
    idle(3);

    // START: 250-cycle MSTRT, MSTP cleared
    send(2'd0, 16'h0000); wait_done(7000); idle(5);
    // STOP: MSTP set, done next cycle
    send(2'd1, 16'h0000); wait_done(7000); idle(5);
    // Reserved op: err with done, MSTP stays set
    send(2'd3, 16'hBEEF); wait_done(7000); idle(5);
    // LOAD with MT12 toggling, MSTP set
    mt_run = 1'b1;
    send(2'd2, 16'o52525); wait_done(7000);
    mt_run = 1'b0; idle(10);
    // LOAD with MT held low: timeout
    send(2'd2, 16'hFFFF); wait_done(7000); idle(5);
    // LOAD aborted by GOJAM mid-drive
    mt_run = 1'b1;
    send(2'd2, 16'h1234); wait_mload(2000); idle(100);
    MGOJAM = 1'b1;
    wait_done(7000); idle(1);
    MGOJAM = 1'b0; mt_run = 1'b0; idle(10);
    // Reset mid-drive, then a normal START
    mt_run = 1'b1;
    send(2'd2, 16'hA5C3); wait_mload(2000); idle(50);
    @(negedge SIM_CLK); #3 SIM_RST_n = 1'b0;
    repeat (3) @(posedge SIM_CLK);
    #2 SIM_RST_n = 1'b1; mt_run = 1'b0;
    idle(5);
    send(2'd0, 16'h0000); wait_done(7000); idle(5);
    // LOAD with MSTP clear
    mt_run = 1'b1;
    send(2'd2, 16'h0F0F); wait_done(7000);
    mt_run = 1'b0; idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
